// File: rtl/trigger_pkg.sv
// Shared trigger definitions: CSR addresses, trigger types and tdata1/tcontrol
// field positions. Used by the CSR file and the trigger matcher.
package trigger_pkg;

  localparam logic [11:0] CSR_TSELECT  = 12'h7A0;
  localparam logic [11:0] CSR_TDATA1   = 12'h7A1;
  localparam logic [11:0] CSR_TDATA2   = 12'h7A2;
  localparam logic [11:0] CSR_TDATA3   = 12'h7A3;
  localparam logic [11:0] CSR_TINFO    = 12'h7A4;
  localparam logic [11:0] CSR_TCONTROL = 12'h7A5;
  localparam logic [11:0] CSR_MCONTEXT = 12'h7A8;

  typedef enum logic [3:0] {
    TT_NONE      = 4'd0,
    TT_MCONTROL  = 4'd2,
    TT_ICOUNT    = 4'd3,
    TT_ITRIGGER  = 4'd4,
    TT_ETRIGGER  = 4'd5,
    TT_MCONTROL6 = 4'd6,
    TT_TMEXT     = 4'd7
  } trig_type_e;

  localparam int unsigned TD1_TYPE_MSB      = 31;
  localparam int unsigned TD1_TYPE_LSB      = 28;
  localparam int unsigned TD1_DMODE         = 27;
  localparam int unsigned TD1_HIT_MCONTROL  = 20;
  localparam int unsigned TD1_HIT_MCONTROL6 = 22;
  localparam int unsigned TD1_HIT_ICOUNT    = 24;
  localparam int unsigned TD1_HIT_IETRIG    = 26;
  localparam int unsigned TD1_COUNT_MSB     = 23;
  localparam int unsigned TD1_COUNT_LSB     = 10;
  localparam int unsigned TD1_M             = 9;
  localparam int unsigned COUNT_W           = 14;

  localparam int unsigned TCTRL_MTE  = 3;
  localparam int unsigned TCTRL_MPTE = 7;

  function automatic logic type_supported(input logic [3:0] t);
    return (t >= 4'd2) && (t <= 4'd7);
  endfunction

  function automatic logic [31:0] hit_mask(input trig_type_e t);
    logic [31:0] m;
    m = '0;
    case (t)
      TT_MCONTROL:              m[TD1_HIT_MCONTROL]  = 1'b1;
      TT_MCONTROL6:             m[TD1_HIT_MCONTROL6] = 1'b1;
      TT_ICOUNT:                m[TD1_HIT_ICOUNT]    = 1'b1;
      TT_ITRIGGER, TT_ETRIGGER: m[TD1_HIT_IETRIG]    = 1'b1;
      default:                  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/trigger_slot.sv
// One trigger slot: tdata1/2/3, the icount counter and the hit-bit logic.
// Write enables arrive already qualified by address, selection and dmode.
module trigger_slot
  import trigger_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_tdata1,
  input  logic        wr_tdata2,
  input  logic        wr_tdata3,
  input  logic [31:0] wdata,
  input  logic        debug_mode,
  input  logic        retire,
  input  logic        mte,
  input  logic        hit,
  output logic [31:0] tdata1,
  output logic [31:0] tdata2,
  output logic [31:0] tdata3,
  output logic [31:0] icount_counter
);

  logic [31:0]        td1_q;
  logic [31:0]        td2_q;
  logic [31:0]        td3_q;
  logic [COUNT_W-1:0] count_q;
  logic [31:0]        td1_wr_val;
  logic               dec_en;
  trig_type_e         ttype;

  assign ttype = trig_type_e'(td1_q[TD1_TYPE_MSB:TD1_TYPE_LSB]);

  assign dec_en = (ttype == TT_ICOUNT) && td1_q[TD1_M] && mte && !debug_mode
                  && retire && (count_q != '0);

  // Unsupported types collapse the whole register to 0 (disabled).
  always_comb begin
    td1_wr_val = '0;
    if (type_supported(wdata[TD1_TYPE_MSB:TD1_TYPE_LSB])) begin
      td1_wr_val = wdata;
      if (!debug_mode) td1_wr_val[TD1_DMODE] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      td1_q   <= '0;
      td2_q   <= '0;
      td3_q   <= '0;
      count_q <= '0;
    end else begin
      if (wr_tdata1) begin
        td1_q <= td1_wr_val;
        if (td1_wr_val[TD1_TYPE_MSB:TD1_TYPE_LSB] == TT_ICOUNT)
          count_q <= td1_wr_val[TD1_COUNT_MSB:TD1_COUNT_LSB];
      end else begin
        if (hit)    td1_q   <= td1_q | hit_mask(ttype);
        if (dec_en) count_q <= count_q - COUNT_W'(1);
      end
      if (wr_tdata2) td2_q <= wdata;
      if (wr_tdata3) td3_q <= wdata;
    end
  end

  assign tdata1 = (ttype == TT_ICOUNT) ? {td1_q[31:24], count_q, td1_q[9:0]} : td1_q;
  assign tdata2 = td2_q;
  assign tdata3 = td3_q;
  assign icount_counter = {{(32 - COUNT_W){1'b0}}, count_q};

endmodule

// File: rtl/trigger_csr_file.sv
// Trigger CSR file: tselect, per-slot tdata, tcontrol and mcontext with a
// 1-cycle CSR read port. Optional mcontext storage via TRIGGER_MCONTEXT_EN.
module trigger_csr_file
  import trigger_pkg::*;
#(
  parameter int unsigned NUM_TRIGGERS = 4,
  parameter logic [31:0] TINFO_MASK   = 32'h0000_00FC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       csr_req,
  input  logic                       csr_we,
  input  logic [11:0]                csr_addr,
  input  logic [31:0]                csr_wdata,
  output logic                       csr_rvalid,
  output logic [31:0]                csr_rdata,
  output logic                       csr_err,
  input  logic                       debug_mode,
  input  logic                       instruction_retired,
  input  logic                       trap_taken,
  input  logic                       mret,
  input  logic [NUM_TRIGGERS-1:0]    trigger_hit,
  output logic [1:0]                 tselect,
  output logic [NUM_TRIGGERS*32-1:0] tdata1,
  output logic [NUM_TRIGGERS*32-1:0] tdata2,
  output logic [NUM_TRIGGERS*32-1:0] tdata3,
  output logic [31:0]                tcontrol,
  output logic [31:0]                mcontext,
  output logic [NUM_TRIGGERS*32-1:0] icount_counter
);

  logic [1:0]              tselect_q;
  logic                    mte_q;
  logic                    mpte_q;
  logic [31:0]             sel_td1, sel_td2, sel_td3;
  logic [31:0]             rdata_d;
  logic                    owned;
  logic                    is_tdata;
  logic                    wr;
  logic                    dmode_block;
  logic [NUM_TRIGGERS-1:0] wr_td1, wr_td2, wr_td3;

  assign wr       = csr_req && csr_we;
  assign is_tdata = (csr_addr == CSR_TDATA1) || (csr_addr == CSR_TDATA2) ||
                    (csr_addr == CSR_TDATA3);
  assign owned    = is_tdata || (csr_addr == CSR_TSELECT) || (csr_addr == CSR_TINFO) ||
                    (csr_addr == CSR_TCONTROL) || (csr_addr == CSR_MCONTEXT);

  always_comb begin
    sel_td1 = '0;
    sel_td2 = '0;
    sel_td3 = '0;
    for (int unsigned i = 0; i < NUM_TRIGGERS; i++) begin
      if (tselect_q == 2'(i)) begin
        sel_td1 = tdata1[i*32 +: 32];
        sel_td2 = tdata2[i*32 +: 32];
        sel_td3 = tdata3[i*32 +: 32];
      end
    end
  end

  assign dmode_block = sel_td1[TD1_DMODE] && !debug_mode;

  always_comb begin
    wr_td1 = '0;
    wr_td2 = '0;
    wr_td3 = '0;
    for (int unsigned i = 0; i < NUM_TRIGGERS; i++) begin
      if (wr && !dmode_block && (tselect_q == 2'(i))) begin
        wr_td1[i] = (csr_addr == CSR_TDATA1);
        wr_td2[i] = (csr_addr == CSR_TDATA2);
        wr_td3[i] = (csr_addr == CSR_TDATA3);
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    case (csr_addr)
      CSR_TSELECT:  rdata_d = {30'b0, tselect_q};
      CSR_TDATA1:   rdata_d = sel_td1;
      CSR_TDATA2:   rdata_d = sel_td2;
      CSR_TDATA3:   rdata_d = sel_td3;
      CSR_TINFO:    rdata_d = TINFO_MASK;
      CSR_TCONTROL: rdata_d = tcontrol;
      CSR_MCONTEXT: rdata_d = mcontext;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rvalid <= 1'b0;
      csr_rdata  <= '0;
      csr_err    <= 1'b0;
    end else begin
      csr_rvalid <= csr_req;
      csr_rdata  <= csr_req ? rdata_d : '0;
      csr_err    <= csr_req && (!owned || (wr && is_tdata && dmode_block));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tselect_q <= '0;
    end else if (wr && (csr_addr == CSR_TSELECT) && (csr_wdata < NUM_TRIGGERS)) begin
      tselect_q <= csr_wdata[1:0];
    end
  end

  // Trap/mret take priority over a same-cycle CSR write to tcontrol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mte_q  <= 1'b0;
      mpte_q <= 1'b0;
    end else if (trap_taken) begin
      mpte_q <= mte_q;
      mte_q  <= 1'b0;
    end else if (mret) begin
      mte_q <= mpte_q;
    end else if (wr && (csr_addr == CSR_TCONTROL)) begin
      mte_q  <= csr_wdata[TCTRL_MTE];
      mpte_q <= csr_wdata[TCTRL_MPTE];
    end
  end

  always_comb begin
    tcontrol             = '0;
    tcontrol[TCTRL_MTE]  = mte_q;
    tcontrol[TCTRL_MPTE] = mpte_q;
  end

`ifdef TRIGGER_MCONTEXT_EN
  logic [31:0] mcontext_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcontext_q <= '0;
    end else if (wr && (csr_addr == CSR_MCONTEXT)) begin
      mcontext_q <= csr_wdata;
    end
  end
  assign mcontext = mcontext_q;
`else
  assign mcontext = '0;
`endif

  assign tselect = tselect_q;

  for (genvar g = 0; g < NUM_TRIGGERS; g++) begin : g_slot
    trigger_slot u_slot (
      .clk            (clk),
      .rst            (rst),
      .wr_tdata1      (wr_td1[g]),
      .wr_tdata2      (wr_td2[g]),
      .wr_tdata3      (wr_td3[g]),
      .wdata          (csr_wdata),
      .debug_mode     (debug_mode),
      .retire         (instruction_retired),
      .mte            (mte_q),
      .hit            (trigger_hit[g]),
      .tdata1         (tdata1[g*32 +: 32]),
      .tdata2         (tdata2[g*32 +: 32]),
      .tdata3         (tdata3[g*32 +: 32]),
      .icount_counter (icount_counter[g*32 +: 32])
    );
  end

endmodule

// File: doc/trigger_csr_file.md
Name: trigger_csr_file

Overview:
- Sequential trigger state store directly upstream of the combinational trigger matcher.
- Holds tselect, per-trigger tdata1/2/3, tcontrol, mcontext and the icount counters. Serves the core's CSR read/write port.
- Applies hardware updates: icount decrement, hit-bit set, tcontrol save/restore on trap and mret.
- All state is exported flat to the matcher every cycle.

Parameters:
- NUM_TRIGGERS, 4: number of trigger slots; 1..4, tselect is 2 bits.
- TINFO_MASK, 32'h0000_00FC: tinfo readback, types 2..7 supported.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- csr_req  in  1  CSR access valid this cycle
- csr_we  in  1  access is a write; meaningful only with csr_req
- csr_addr  in  12  CSR address
- csr_wdata  in  32  write data
- csr_rvalid  out  1  pulses 1 cycle after every csr_req
- csr_rdata  out  32  read data, valid with csr_rvalid
- csr_err  out  1  with csr_rvalid: address not owned, or write blocked by dmode
- debug_mode  in  1  core in debug mode
- instruction_retired  in  1  one instruction retired this cycle
- trap_taken  in  1  M-mode trap entry this cycle
- mret  in  1  mret retired this cycle
- trigger_hit  in  NUM_TRIGGERS  per-slot match from the matcher
- tselect  out  2  current selection
- tdata1 / tdata2 / tdata3  out  NUM_TRIGGERS x 32  per-slot state; tdata1 count field reflects the live counter
- tcontrol  out  32  bit3 mte, bit7 mpte, others 0
- mcontext  out  32  machine context
- icount_counter  out  NUM_TRIGGERS x 32  zero-extended 14-bit counters

Behaviour:
- Reset (async): all registers 0. All tdata1 type = 0 (disabled). tcontrol = 0. csr_rvalid = 0, csr_rdata = 0, csr_err = 0.
- Addresses: 0x7A0 tselect, 0x7A1-0x7A3 tdata1-3 of the selected slot, 0x7A4 tinfo (read-only; writes ignored, no err), 0x7A5 tcontrol, 0x7A8 mcontext. Any other address: rdata 0, err 1, no state change.
- Read latency 1 cycle. rdata samples state before any same-cycle write (read-old).
- Writes commit on the edge ending the csr_req cycle.
- tselect write: value >= NUM_TRIGGERS is ignored; old value kept.
- dmode (tdata1[27]):
  - Writable only when debug_mode = 1; otherwise the written dmode bit is forced to 0.
  - When the selected slot has dmode = 1 and debug_mode = 0, writes to tdata1-3 are dropped and csr_err = 1.
- tdata1 type field [31:28] is WARL:
  - Values 2-7 are stored as written.
  - Any other value stores the whole tdata1 as 0.
- Type 3 tdata1 write loads counter <= wdata[23:10]. Readback of [23:10] shows the live counter.
- Icount decrement, per slot. Condition: type 3, tdata1[9] = 1, tcontrol.mte = 1, !debug_mode, instruction_retired, counter != 0. Action: counter -= 1. Counter never wraps below 0.
- Hit set, when trigger_hit[i] = 1:
  - type 2: bit 20
  - type 6: bit 22
  - type 3: bit 24
  - types 4/5: bit 26
  - type 7: none
  - Hit bits are cleared only by CSR write.
- tcontrol:
  - trap_taken: mpte <= mte, mte <= 0.
  - mret (and no trap): mte <= mpte.
  - trap_taken and mret together: trap wins.
- Priority on the same slot/register, same cycle: csr write > hardware update.
  - Exception: tcontrol, where trap/mret beat a CSR write.
  - A CSR write to the selected slot's tdata1 discards that cycle's decrement and hit-set for that slot.
- Non-selected slots always receive hardware updates.
- Reset mid-access: pending csr_rvalid is cancelled.

Optional Feature:
- TRIGGER_MCONTEXT_EN defined: 32-bit mcontext register at 0x7A8, fully R/W, reset 0.
- Not defined: 0x7A8 reads 0, writes ignored, csr_err = 0, mcontext output tied 0.

Decomposition:
- Shared package trigger_pkg:
  - CSR address constants
  - trigger type enum (0, 2-7)
  - tdata1 field positions: type, dmode, hit-bit per type, count [23:10], m [9]
  - tcontrol bit positions
- The matcher consumes the same package.
- Sub-module trigger_slot holds one slot's tdata1/2/3, counter and hit logic. It takes the write-enable/data, retire, mte, debug and hit inputs. It is instantiated NUM_TRIGGERS times by generate.

Test Plan:
- Write tselect=2, tdata2=0x8000_0040, read tdata2 -> rdata 0x8000_0040 one cycle after req. Write tselect=5 -> tselect stays 2.
- Slot 1 tdata1 = type3, m = 1, count = 3, tcontrol.mte = 1. Retire 5 instructions -> counter 2, 1, 0, 0, 0; icount_counter[1] = 0, no wrap.
- Slot 0 dmode = 1 set while debug_mode = 1. Leave debug, write tdata1 -> unchanged, csr_err = 1. Write tdata1 type = 9 in debug -> tdata1 reads 0.
- tcontrol mte = 1, pulse trap_taken -> tcontrol = 0x80. Pulse mret -> 0x88. Trap and mret together -> mte = 0.
- Slot 2 type 6, pulse trigger_hit[2] -> tdata1[22] = 1. In the same cycle a CSR write of tdata1 (tselect = 2) with bit22 = 0 -> write wins, bit 0.
- Assert rst mid-read: csr_rvalid = 0 next cycle, all tdata = 0. With TRIGGER_MCONTEXT_EN undefined, write 0x7A8 = 0x1234 -> reads 0, err 0.
